// File: rtl/dtrigger_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dtrigger_pipe
//  Purpose  : Elastic WIDTH x DEPTH register pipeline with a valid/ready
//             handshake on both sides, bubble collapse, synchronous flush and
//             a registered occupancy count.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH  data word width in bits (>= 1)
//    DEPTH  number of register stages (>= 1)
//    CW     occupancy count width, derived from DEPTH
//  Ports
//    clk        rising-edge clock
//    reset      asynchronous active-low reset
//    in_valid   upstream word present
//    in_ready   pipeline accepts a word this cycle
//    in_data    upstream word
//    out_valid  word available at the tail stage
//    out_ready  downstream takes the tail word this cycle
//    out_data   tail word, straight from the tail register
//    flush      synchronous clear of all valid bits
//    count      number of occupied stages, 0..DEPTH
// ============================================================================
module dtrigger_pipe #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  // Stage state: index 0 is the head, DEPTH-1 the tail.
  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_move;   // stage k hands its word on this cycle
  logic [DEPTH-1:0] w_open;   // stage k can take a new word this cycle
  logic [DEPTH-1:0] w_ld;     // stage k loads a word on the next edge
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_d_src [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;

  // --------------------------------------------------------------------------
  // Ready chain, evaluated from the tail toward the head. A stage moves when
  // the slot below it is open; a slot is open when it is empty or its own
  // occupant moves. An empty stage is therefore always open, which is what
  // lets words pack into holes while the tail is stalled.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [DEPTH:0] open_x;
    open_x        = '0;
    open_x[DEPTH] = out_ready;
    w_move        = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_move[k] = r_v[k] & open_x[k+1];
      open_x[k] = ~r_v[k] | w_move[k];
    end
    w_open = open_x[DEPTH-1:0];
  end

  assign in_ready   = w_open[0] & ~flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_move[DEPTH-1];

  // Load enables: the head loads on an input transfer, every other stage
  // loads when the stage above it moves.
  generate
    if (DEPTH == 1) begin : g_ld_single
      assign w_ld = w_in_xfer;
    end else begin : g_ld_chain
      assign w_ld = {w_move[DEPTH-2:0], w_in_xfer};
    end
  endgenerate

  // Data source for each stage.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_src
      if (k == 0) begin : g_head
        assign w_d_src[k] = in_data;
      end else begin : g_link
        assign w_d_src[k] = r_d[k-1];
      end
    end
  endgenerate

  // A stage ends up valid if it loads, or if it was valid and did not move.
  // Flush drops every valid bit; a tail word leaving in the flush cycle has
  // already been taken by the consumer.
  assign w_v_nxt = flush ? '0 : (w_ld | (r_v & ~w_move));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
    end else begin
      r_v <= w_v_nxt;
    end
  end

  // Data registers only change when loading; contents of empty stages are
  // don't-care and are left alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_ld[k]) begin
          r_d[k] <= w_d_src[k];
        end
      end
    end
  end

  // Occupancy tracks transfers rather than recounting valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dtrigger_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtrigger_pipe
//  Purpose  : Self-checking bench for dtrigger_pipe (WIDTH=16, DEPTH=4).
//             The reference model is a queue of words, each tagged with the
//             stage it occupies; words advance one stage per cycle but never
//             past the word ahead of them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dtrigger_pipe;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, oldest word first.
  int               q_pos[$];
  logic [WIDTH-1:0] q_dat[$];
  bit               last_ix;
  bit               last_ox;

  dtrigger_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic bit m_ovalid();
    return (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
  endfunction

  // A full pipeline accepts only when the tail leaves; any hole means the
  // head slot is reachable.
  function automatic bit m_iready();
    return !flush && ((q_pos.size() < DEPTH) || out_ready);
  endfunction

  // One clock edge: advance the model with the inputs present before it.
  task automatic step();
    int lim;
    last_ox = out_ready && m_ovalid();
    last_ix = in_valid && m_iready();
    @(posedge clk);
    if (last_ox) begin
      void'(q_pos.pop_front());
      void'(q_dat.pop_front());
    end
    lim = DEPTH;
    foreach (q_pos[i]) begin
      q_pos[i] = (q_pos[i] + 1 < lim - 1) ? q_pos[i] + 1 : lim - 1;
      lim = q_pos[i];
    end
    if (flush) begin
      q_pos.delete();
      q_dat.delete();
    end
    if (last_ix) begin
      q_pos.push_back(0);
      q_dat.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    #12;
    n_tests++; if (count !== 0)     begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_tests++; if (out_valid !== 0) begin n_fail++; $display("FAIL rst_ovalid: got %0b want 0", out_valid); end
    n_tests++; if (out_data !== 0)  begin n_fail++; $display("FAIL rst_odata: got %h want 0000", out_data); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1) begin n_fail++; $display("FAIL rst_iready: got %0b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'hA000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if (count !== 3)     begin n_fail++; $display("FAIL rst_pre_count: got %0d want 3", count); end
    n_tests++; if (out_valid !== 1) begin n_fail++; $display("FAIL rst_pre_ovalid: got %0b want 1", out_valid); end
    #2 reset = 1'b0;
    #1;
    q_pos.delete(); q_dat.delete();
    n_tests++; if (count !== 0)     begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    n_tests++; if (out_valid !== 0) begin n_fail++; $display("FAIL rst_mid_ovalid: got %0b want 0", out_valid); end
    n_tests++; if (out_data !== 0)  begin n_fail++; $display("FAIL rst_mid_odata: got %h want 0000", out_data); end
    @(negedge clk) reset = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1) begin n_fail++; $display("FAIL rst_rel_iready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    int sent = 0;
    int first_out = -1;
    logic [WIDTH-1:0] exp_next = 16'h0001;
    out_ready = 1'b1;
    for (int c = 0; c < 16 + DEPTH + 2; c++) begin
      in_valid = (sent < 16);
      in_data  = 16'(sent + 1);
      @(negedge clk);
      if (out_valid === 1'b1 && first_out < 0) first_out = c;
      n_tests++; if (out_valid !== m_ovalid()) begin n_fail++; $display("FAIL stream_ovalid c%0d: got %0b want %0b", c, out_valid, m_ovalid()); end
      n_tests++; if (count !== CW'(q_pos.size())) begin n_fail++; $display("FAIL stream_count c%0d: got %0d want %0d", c, count, q_pos.size()); end
      if (m_ovalid()) begin
        n_tests++; if (out_data !== exp_next) begin n_fail++; $display("FAIL stream_order c%0d: got %h want %h", c, out_data, exp_next); end
        exp_next++;
      end
      step();
      if (last_ix) sent++;
    end
    n_tests++; if (first_out !== DEPTH) begin n_fail++; $display("FAIL stream_latency: got %0d want %0d", first_out, DEPTH); end
    n_tests++; if (exp_next !== 16'h0011) begin n_fail++; $display("FAIL stream_delivered: got %0d want 16", exp_next - 1); end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    int got[$];
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (nxt <= 6); in_data = 16'(nxt);
      @(negedge clk);
      n_tests++; if (in_ready !== m_iready()) begin n_fail++; $display("FAIL bp_iready c%0d: got %0b want %0b", c, in_ready, m_iready()); end
      step();
      if (last_ix) nxt++;
    end
    @(negedge clk);
    n_tests++; if (count !== 4)    begin n_fail++; $display("FAIL bp_count: got %0d want 4", count); end
    n_tests++; if (nxt !== 5)      begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", nxt - 1); end
    n_tests++; if (in_ready !== 0) begin n_fail++; $display("FAIL bp_full_iready: got %0b want 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (nxt <= 6); in_data = 16'(nxt);
      #1;
      if (out_valid === 1'b1) got.push_back(int'(out_data));
      step();
      if (last_ix) nxt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++; if (got.size() !== 6) begin n_fail++; $display("FAIL bp_ndeliver: got %0d want 6", got.size()); end
    foreach (got[i]) begin
      n_tests++; if (got[i] !== i + 1) begin n_fail++; $display("FAIL bp_word%0d: got %0d want %0d", i, got[i], i + 1); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0B00;
    step();
    in_valid = 1'b0;
    repeat (DEPTH) step();
    @(negedge clk);
    n_tests++; if (out_valid !== 1 || count !== 1) begin n_fail++; $display("FAIL bub_tail: got v=%0b n=%0d want v=1 n=1", out_valid, count); end
    for (int c = 0; c < 40 && q_pos.size() < DEPTH; c++) begin
      in_valid = 1'($urandom % 2); in_data = 16'h0B01 + 16'(c);
      @(negedge clk);
      n_tests++; if (count !== CW'(q_pos.size())) begin n_fail++; $display("FAIL bub_count c%0d: got %0d want %0d", c, count, q_pos.size()); end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (count !== 4)          begin n_fail++; $display("FAIL bub_full: got %0d want 4", count); end
    n_tests++; if (in_ready !== 0)       begin n_fail++; $display("FAIL bub_iready: got %0b want 0", in_ready); end
    n_tests++; if (out_data !== 16'h0B00) begin n_fail++; $display("FAIL bub_tailword: got %h want 0b00", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_inout();
    int ins = 0, outs = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_data = 16'hC000 + 16'(c);
      @(negedge clk);
      n_tests++; if (in_ready !== 1) begin n_fail++; $display("FAIL full_iready c%0d: got %0b want 1", c, in_ready); end
      n_tests++; if (count !== 4)    begin n_fail++; $display("FAIL full_count c%0d: got %0d want 4", c, count); end
      n_tests++; if (out_data !== q_dat[0]) begin n_fail++; $display("FAIL full_odata c%0d: got %h want %h", c, out_data, q_dat[0]); end
      step();
      if (last_ix) ins++;
      if (last_ox) outs++;
    end
    in_valid = 1'b0;
    n_tests++; if (ins !== 8 || outs !== 8) begin n_fail++; $display("FAIL full_xfers: got in=%0d out=%0d want 8/8", ins, outs); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (DEPTH + 1) step();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 16'hD000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    @(negedge clk);
    n_tests++; if (count !== 3 || out_valid !== 1) begin n_fail++; $display("FAIL fl_pre: got n=%0d v=%0b want n=3 v=1", count, out_valid); end
    in_valid = 1'b1; in_data = 16'hDDDD; out_ready = 1'b1; flush = 1'b1;
    #1;
    n_tests++; if (in_ready !== 0)          begin n_fail++; $display("FAIL fl_iready: got %0b want 0", in_ready); end
    n_tests++; if (out_data !== 16'hD001)   begin n_fail++; $display("FAIL fl_odata: got %h want d001", out_data); end
    step();
    n_tests++; if (last_ox !== 1'b1)        begin n_fail++; $display("FAIL fl_delivered: got %0b want 1", last_ox); end
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (count !== 0)     begin n_fail++; $display("FAIL fl_count: got %0d want 0", count); end
    n_tests++; if (out_valid !== 0) begin n_fail++; $display("FAIL fl_ovalid: got %0b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 20) == 0;
      in_data   = 16'($urandom);
      @(negedge clk);
      n_tests++; if (in_ready !== m_iready()) begin n_fail++; $display("FAIL rnd_iready c%0d: got %0b want %0b", c, in_ready, m_iready()); end
      n_tests++; if (out_valid !== m_ovalid()) begin n_fail++; $display("FAIL rnd_ovalid c%0d: got %0b want %0b", c, out_valid, m_ovalid()); end
      n_tests++; if (count !== CW'(q_pos.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, q_pos.size()); end
      if (m_ovalid()) begin
        n_tests++; if (out_data !== q_dat[0]) begin n_fail++; $display("FAIL rnd_odata c%0d: got %h want %h", c, out_data, q_dat[0]); end
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_full_inout();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dtrigger_pipe.md
# dtrigger_pipe

Parametrised, elastic register pipeline that generalises the team's single-stage D-trigger registers to WIDTH bits and DEPTH stages, with a valid/ready handshake on both sides, bubble collapse, synchronous flush and an occupancy count. It sits between datapath blocks that need a fixed register delay but must tolerate downstream back-pressure, for example buffering 16-bit sample words ahead of a consumer that stalls.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; one clock, no other reset
- in_valid  input  1  upstream word present
- in_ready  output  1  pipeline accepts a word this cycle
- in_data  input  WIDTH  upstream word
- out_valid  output  1  word available at tail
- out_ready  input  1  downstream takes the tail word this cycle
- out_data  output  WIDTH  tail word
- flush  input  1  synchronous clear of all stages
- count  output  CW  number of occupied stages, 0..DEPTH

## Operation
- Stage k (0 = head, DEPTH-1 = tail) holds a valid bit v[k] and data word d[k].
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1] (direct from registers, no logic on data).
- Stage k "moves" when v[k] & (k==DEPTH-1 ? out_ready : slot k+1 open).
- Slot k open = !v[k] | move[k]. Bubble collapse: a word advances into any empty stage even while stages further down are stalled.
- in_ready = slot 0 open & !flush.
- On each edge, stage k+1 loads d[k] and v[k+1]<=1 when move[k]; otherwise, if move[k+1], v[k+1]<=0. Stage 0 loads in_data on input transfer.
- Data registers of empty or non-loading stages hold their value; only valid bits matter.
- flush=1: all v[k]<=0 next edge; input is not accepted (in_ready=0). An output transfer in the same cycle still completes (word counts as delivered). Data registers are not cleared.
- count = number of set v[k], registered, updated the same edge as v. Equals previous count + input transfer - output transfer, or 0 after flush.
- Reset (asserted at any time, including mid-transfer): all v[k]=0, all d[k]=0, count=0 immediately and asynchronously; in_ready=1 when flush=0; out_valid=0; out_data=0.

## Timing
- Latency, empty pipeline, no stall: word accepted at edge N appears at out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from in_data to out_data.
- Throughput: one word per cycle with out_ready held high, sustained indefinitely.
- Full (count==DEPTH) with out_ready=0: in_ready=0. Full with out_ready=1: in_ready=1 in the same cycle, so simultaneous input and output transfers occur and count stays DEPTH.
- Empty: out_valid=0; out_ready ignored.
- in_ready depends combinationally on out_ready and flush (ready path through DEPTH stages); no combinational path from in_valid/in_data to outputs.
- Reset release: first input transfer possible at the first rising edge after reset deasserts.

## Test plan
- Reset: assert reset mid-stream with count=3 -> out_valid=0, out_data=0, count=0 immediately; in_ready=1 after release.
- Streaming: DEPTH=4, WIDTH=16, push 0x0001..0x0010 back-to-back, out_ready=1 -> first word at out_data 4 cycles after acceptance, one word per cycle, order preserved, count steady at 4.
- Back-pressure: out_ready=0, push 6 words -> accepted 4 (in_ready drops after 4th), count=4; release out_ready -> words 1..6 delivered in order, none lost or duplicated.
- Bubble collapse: stall tail with one word, push with gaps on in_valid -> words pack into empty stages, count reaches 4 while out_ready=0.
- Simultaneous full in/out: count=4, in_valid=1, out_ready=1 for 8 cycles -> 8 in, 8 out, count stays 4.
- Flush: count=3, out_ready=1, in_valid=1, flush=1 for one cycle -> tail word delivered that cycle, input not accepted, count=0 and out_valid=0 next cycle.
